updown_counter_ctrl: RTL
========================

Name: updown_counter_ctrl

Overview:
Parametrised up/down counter engine with a run/stop FSM. It takes single-cycle button edge pulses and UART receive bytes (ASCII commands), and drives mode/run LEDs, a binary count for the FND controller, and boundary status. It generalises the fixed 0..9999 up/down counter in three ways:
- configurable modulus and tick rate;
- selectable wrap or saturate policy at the boundaries;
- explicit force-direction commands.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
TICK_HZ, 10, count-update rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an integer multiple of TICK_HZ and >= 2*TICK_HZ
MAX_COUNT, 9999, largest count value; the range is 0..MAX_COUNT
WIDTH, $clog2(MAX_COUNT+1), count width
WRAP_DEFAULT, 1, boundary policy after reset (1 = wrap, 0 = saturate)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn_mode  in  1  1-cycle pulse: toggle direction
btn_run_stop  in  1  1-cycle pulse: toggle run/stop
btn_clear  in  1  1-cycle pulse: clear count
rx_data  in  8  UART received byte, valid only when rx_done=1
rx_done  in  1  1-cycle strobe: rx_data valid
led_mode  out  2  2'b01 = up, 2'b10 = down
led_run_stop  out  2  2'b01 = STOP, 2'b10 = RUN
count  out  WIDTH  current count, registered
wrap_mode  out  1  1 = wrap policy, 0 = saturate policy
boundary_pulse  out  1  1-cycle pulse when a tick wraps or hits a saturation limit

Behaviour:
- Reset (synchronous, active-high) sets: count=0, direction=up, state=STOP, wrap_mode=WRAP_DEFAULT, prescaler=0, boundary_pulse=0. Outputs therefore reset to led_mode=01 and led_run_stop=01. Reset overrides all other inputs in the same cycle.
- Command decode: rx_data is decoded only when rx_done=1. Letters are case-insensitive; all other bytes are ignored.
  - 'M' = toggle direction
  - 'R' = toggle run/stop
  - 'C' = clear
  - 'W' = toggle wrap_mode
  - 'U' = force direction up
  - 'D' = force direction down
- Combining buttons and UART: a button pulse and a UART command of the same kind in the same cycle count as ONE event, not two toggles. A force command ('U'/'D') overrides btn_mode in the same cycle.
- Latency: a command or tick at cycle n is visible on the outputs at cycle n+1. There is no internal buffering. A command arriving while the previous one is still being applied is not possible, because every command takes effect in one cycle.
- FSM states: STOP, RUN.
  - STOP -> RUN on a run/stop toggle.
  - RUN -> STOP on a run/stop toggle, or on a saturation stop (below).
  - Clear does not change the state.
- Prescaler: counts 0..TICK_DIV-1 while in RUN, and is held at 0 in STOP.
  - tick asserts when the prescaler = TICK_DIV-1, then the prescaler returns to 0.
  - The first tick after entering RUN therefore occurs TICK_DIV cycles later.
- On tick, direction up:
  - count < MAX_COUNT: count+1.
  - count = MAX_COUNT, wrap mode: count -> 0, boundary_pulse=1.
  - count = MAX_COUNT, saturate mode: count holds, boundary_pulse=1, FSM -> STOP.
- On tick, direction down: mirror image. At 0 the count wraps to MAX_COUNT, or holds and stops in saturate mode.
- Clear: count -> 0 and the prescaler -> 0. Clear has priority over a tick in the same cycle, so no increment happens in that cycle.
- Simultaneous events in one cycle are all applied (clear, direction, run, wrap). A tick in that cycle uses the OLD direction and OLD wrap_mode.
- Direction change mid-run: takes effect from the next tick. The prescaler is not reset.
- Toggling wrap_mode while saturated in STOP: no immediate count change.
- Invariants: count is never > MAX_COUNT. boundary_pulse is only ever 1 cycle wide.

Decomposition:
- Package updown_pkg holds:
  - typedef enum logic {STOP, RUN} run_state_e;
  - typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
  - ASCII command constants (CMD_MODE, CMD_RUN, CMD_CLEAR, CMD_WRAP, CMD_UP, CMD_DOWN), upper and lower case;
  - LED encoding constants.
- Sub-module tick_gen (parameter DIV, inputs clk/reset/en/clr, output tick) holds the prescaler.
- Command decode, the FSM and the counter datapath stay in the top of this block.

Test Plan (CLK_HZ=100, TICK_HZ=10 so TICK_DIV=10, MAX_COUNT=9):
1. Reset, then btn_run_stop pulse at cycle 0 -> led_run_stop=10 at cycle 1; count=1 at cycle 11, 2 at cycle 21.
2. RUN, up, wrap, count=9; next tick -> count=0, with boundary_pulse high for exactly 1 cycle. Then 'D' via UART, count=0, next tick -> count=9 with boundary_pulse.
3. 'W' (saturate), down, RUN, count=1 -> tick gives count=0 and stays RUN; next tick gives boundary_pulse, count holds 0, led_run_stop=01.
4. btn_mode pulse and rx 'm' in the same cycle -> direction toggles once (01 -> 10). rx 'U' plus btn_mode in the same cycle -> direction up.
5. btn_clear on the same cycle as a tick with count=5 -> count=0 the next cycle, state still RUN, next increment 10 cycles later.
6. rx_done with bytes 'x', 0x00, 'r' -> only 'r' toggles run. Reset asserted mid-RUN with count=7 -> next cycle count=0, up, STOP, wrap_mode=WRAP_DEFAULT.

Source files
------------

// File: rtl/updown_pkg.sv
// Shared types and constants for the up/down counter controller.
// Holds FSM/direction enums, ASCII command bytes and LED encodings.
package updown_pkg;

    typedef enum logic {STOP, RUN} run_state_e;
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    localparam logic [7:0] CMD_MODE     = "M";
    localparam logic [7:0] CMD_MODE_LC  = "m";
    localparam logic [7:0] CMD_RUN      = "R";
    localparam logic [7:0] CMD_RUN_LC   = "r";
    localparam logic [7:0] CMD_CLEAR    = "C";
    localparam logic [7:0] CMD_CLEAR_LC = "c";
    localparam logic [7:0] CMD_WRAP     = "W";
    localparam logic [7:0] CMD_WRAP_LC  = "w";
    localparam logic [7:0] CMD_UP       = "U";
    localparam logic [7:0] CMD_UP_LC    = "u";
    localparam logic [7:0] CMD_DOWN     = "D";
    localparam logic [7:0] CMD_DOWN_LC  = "d";

    localparam logic [1:0] LED_UP   = 2'b01;
    localparam logic [1:0] LED_DOWN = 2'b10;
    localparam logic [1:0] LED_STOP = 2'b01;
    localparam logic [1:0] LED_RUN  = 2'b10;

    // True when a byte matches either case of a command letter.
    function automatic logic is_cmd(
        input logic [7:0] b,
        input logic [7:0] uc,
        input logic [7:0] lc
    );
        return (b == uc) || (b == lc);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// Held at zero while disabled or cleared.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler counts 0..DIV-1 while enabled, else parks at 0.
    always_ff @(posedge clk) begin
        if (reset || clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/updown_counter_ctrl.sv
// Up/down counter engine with run/stop FSM and UART command decode.
// Supports configurable modulus, tick rate and wrap/saturate policy.
module updown_counter_ctrl
    import updown_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 10,
    parameter int MAX_COUNT    = 9999,
    parameter int WIDTH        = $clog2(MAX_COUNT + 1),
    parameter bit WRAP_DEFAULT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_run_stop,
    input  logic             btn_clear,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
    output logic [1:0]       led_mode,
    output logic [1:0]       led_run_stop,
    output logic [WIDTH-1:0] count,
    output logic             wrap_mode,
    output logic             boundary_pulse
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    run_state_e state, state_next;
    dir_e       dir, dir_next;
    logic       tick;
    logic       sat_stop;
    logic       bnd_next;
    logic [WIDTH-1:0] count_next;

    logic rx_mode, rx_run, rx_clear, rx_wrap, rx_up, rx_down;
    logic mode_evt, run_evt, clear_evt;

    assign rx_mode  = rx_done && is_cmd(rx_data, CMD_MODE, CMD_MODE_LC);
    assign rx_run   = rx_done && is_cmd(rx_data, CMD_RUN, CMD_RUN_LC);
    assign rx_clear = rx_done && is_cmd(rx_data, CMD_CLEAR, CMD_CLEAR_LC);
    assign rx_wrap  = rx_done && is_cmd(rx_data, CMD_WRAP, CMD_WRAP_LC);
    assign rx_up    = rx_done && is_cmd(rx_data, CMD_UP, CMD_UP_LC);
    assign rx_down  = rx_done && is_cmd(rx_data, CMD_DOWN, CMD_DOWN_LC);

    // Same-kind button and UART events merge into a single event.
    assign mode_evt  = btn_mode | rx_mode;
    assign run_evt   = btn_run_stop | rx_run;
    assign clear_evt = btn_clear | rx_clear;

    // Prescaler restarts on clear and whenever the FSM leaves RUN.
    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (state == RUN),
        .clr   (clear_evt || (state == RUN && state_next == STOP)),
        .tick  (tick)
    );

    // Run/stop state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next state: toggle on run event, forced STOP on saturation.
    always_comb begin
        state_next = state;
        if (run_evt) begin
            state_next = (state == STOP) ? RUN : STOP;
        end
        if (sat_stop) begin
            state_next = STOP;
        end
    end

    // LED encodings for run state and direction.
    always_comb begin
        led_run_stop = (state == RUN) ? LED_RUN : LED_STOP;
        led_mode     = (dir == DIR_UP) ? LED_UP : LED_DOWN;
    end

    // Direction: force commands win over a toggle.
    always_comb begin
        dir_next = dir;
        if (rx_up) begin
            dir_next = DIR_UP;
        end else if (rx_down) begin
            dir_next = DIR_DOWN;
        end else if (mode_evt) begin
            dir_next = (dir == DIR_UP) ? DIR_DOWN : DIR_UP;
        end
    end

    // Count update; a tick sees the pre-update direction and policy.
    always_comb begin
        count_next = count;
        bnd_next   = 1'b0;
        sat_stop   = 1'b0;
        if (clear_evt) begin
            count_next = '0;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (count < MAX_VAL) begin
                    count_next = count + 1'b1;
                end else begin
                    bnd_next = 1'b1;
                    if (wrap_mode) count_next = '0;
                    else sat_stop = 1'b1;
                end
            end else begin
                if (count != '0) begin
                    count_next = count - 1'b1;
                end else begin
                    bnd_next = 1'b1;
                    if (wrap_mode) count_next = MAX_VAL;
                    else sat_stop = 1'b1;
                end
            end
        end
    end

    // Datapath registers: count, direction, policy and boundary pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count          <= '0;
            dir            <= DIR_UP;
            wrap_mode      <= WRAP_DEFAULT;
            boundary_pulse <= 1'b0;
        end else begin
            count          <= count_next;
            dir            <= dir_next;
            wrap_mode      <= rx_wrap ? ~wrap_mode : wrap_mode;
            boundary_pulse <= bnd_next;
        end
    end

endmodule
